// File: rtl/mem_utils.sv
// ============================================================================
//  Module      : mem_utils (package)
//  Description : Shared memory-path types: read-return owner and store sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_utils;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_DBG  = 2'd2
  } arb_owner_e;

  // Store-size encoding shared by lsu, data_memory and the arbiter.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } store_size_e;

endpackage

`default_nettype wire

// File: rtl/arb_starve_counter.sv
// ============================================================================
//  Module      : arb_starve_counter
//  Description : Saturating count of consecutive refused debug cycles; flags
//                when the debug port must be forced through.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_counter
  import mem_utils::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_grant,
  output logic o_force
);

  localparam logic [3:0] c_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
    end else if (!i_req || i_grant) begin
      r_count <= 4'd0;
    end else if (r_count != c_MAX_WAIT) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_force = (r_count == c_MAX_WAIT);

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Core-priority arbiter sharing data_memory between the LSU and
//                a debug/DMA port. Optional starvation guard is enabled by
//                defining DATA_MEM_ARB_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
  import mem_utils::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_read_en,
  input  logic        core_write_en,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_store_size,
  input  logic [31:0] core_write_data,
  output logic        core_grant,
  output logic        core_stall,
  output logic [31:0] core_read_data,
  output logic        core_read_valid,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [1:0]  dbg_store_size,
  input  logic [31:0] dbg_write_data,
  output logic        dbg_grant,
  output logic [31:0] dbg_read_data,
  output logic        dbg_read_valid,
  output logic        mem_read_en,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_store_size,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  logic       w_core_req;
  logic       w_dbg_req;
  logic       w_dbg_win;
  arb_owner_e r_rd_owner;
  arb_owner_e w_owner_nxt;

  // Requests are masked during reset so no grant or enable can leak out.
  assign w_core_req = (core_read_en | core_write_en) & ~rst;
  assign w_dbg_req  = dbg_req & ~rst;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  logic w_force;

  arb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_counter (
    .clk     (clk),
    .rst     (rst),
    .i_req   (w_dbg_req),
    .i_grant (dbg_grant),
    .o_force (w_force)
  );

  assign w_dbg_win = w_dbg_req & w_force;
`else
  assign w_dbg_win = 1'b0;
`endif

  assign core_grant = w_core_req & ~w_dbg_win;
  assign dbg_grant  = w_dbg_req & (~w_core_req | w_dbg_win);
  assign core_stall = w_core_req & ~core_grant;

  // A core cycle with both enables set is a store.
  always_comb begin
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = 32'd0;
    mem_store_size = 2'd0;
    mem_write_data = 32'd0;
    w_owner_nxt    = OWNER_NONE;
    if (core_grant) begin
      mem_read_en    = ~core_write_en;
      mem_write_en   = core_write_en;
      mem_addr       = core_addr;
      mem_store_size = core_store_size;
      mem_write_data = core_write_data;
      w_owner_nxt    = core_write_en ? OWNER_NONE : OWNER_CORE;
    end else if (dbg_grant) begin
      mem_read_en    = ~dbg_we;
      mem_write_en   = dbg_we;
      mem_addr       = dbg_addr;
      mem_store_size = dbg_store_size;
      mem_write_data = dbg_write_data;
      w_owner_nxt    = dbg_we ? OWNER_NONE : OWNER_DBG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_owner <= OWNER_NONE;
    end else begin
      r_rd_owner <= w_owner_nxt;
    end
  end

  assign core_read_valid = (r_rd_owner == OWNER_CORE);
  assign dbg_read_valid  = (r_rd_owner == OWNER_DBG);
  assign core_read_data  = core_read_valid ? mem_read_data : 32'd0;
  assign dbg_read_data   = dbg_read_valid  ? mem_read_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Directed self-checking bench for data_mem_arbiter with a
//                word-memory stand-in and a rules-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int MAX_WAIT = 4;

  logic        clk, rst;
  logic        core_read_en, core_write_en;
  logic [31:0] core_addr, core_write_data;
  logic [1:0]  core_store_size;
  logic        core_grant, core_stall, core_read_valid;
  logic [31:0] core_read_data;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_write_data;
  logic [1:0]  dbg_store_size;
  logic        dbg_grant, dbg_read_valid;
  logic [31:0] dbg_read_data;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_write_data;
  logic [1:0]  mem_store_size;
  logic [31:0] mem_read_data;

  int n_vec = 0;
  int n_err = 0;

  data_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .core_read_en(core_read_en), .core_write_en(core_write_en),
    .core_addr(core_addr), .core_store_size(core_store_size),
    .core_write_data(core_write_data), .core_grant(core_grant),
    .core_stall(core_stall), .core_read_data(core_read_data),
    .core_read_valid(core_read_valid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_store_size(dbg_store_size), .dbg_write_data(dbg_write_data),
    .dbg_grant(dbg_grant), .dbg_read_data(dbg_read_data),
    .dbg_read_valid(dbg_read_valid),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_store_size(mem_store_size),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] w);
    return 32'hC0DE0000 | w;
  endfunction

  // Memory stand-in driven purely by the DUT's mem_* outputs.
  logic [31:0] env_mem [int unsigned];
  initial mem_read_data = 32'd0;
  always @(posedge clk) begin
    if (mem_write_en) env_mem[mem_addr >> 2] = mem_write_data;
    if (mem_read_en)
      mem_read_data <= env_mem.exists(mem_addr >> 2) ? env_mem[mem_addr >> 2]
                                                      : init_word(mem_addr >> 2);
    else
      mem_read_data <= $urandom;
  end

  // Reference model: owner 0=none, 1=core, 2=dbg.
  logic [31:0] ref_mem [int unsigned];
  int          m_owner = 0;
  int          m_wait  = 0;
  logic [31:0] m_rdata = 32'd0;

  function automatic logic [31:0] ref_rd(input logic [31:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [1:0] mgrant();
    bit creq, dreq, win;
    creq = !rst && (core_read_en || core_write_en);
    dreq = !rst && dbg_req;
    win  = GUARD && dreq && (m_wait == MAX_WAIT);
    return {dreq && (!creq || win), creq && !win};
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0] g;
    if (rst) begin
      m_owner = 0;
      m_wait  = 0;
    end else begin
      g = mgrant();
      m_owner = 0;
      if (g[0]) begin
        if (core_write_en) ref_mem[core_addr >> 2] = core_write_data;
        else begin m_owner = 1; m_rdata = ref_rd(core_addr >> 2); end
      end else if (g[1]) begin
        if (dbg_we) ref_mem[dbg_addr >> 2] = dbg_write_data;
        else begin m_owner = 2; m_rdata = ref_rd(dbg_addr >> 2); end
      end
      if (!dbg_req || g[1]) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] g;
    bit         creq;
    g    = mgrant();
    creq = !rst && (core_read_en || core_write_en);
    chk("core_grant", 32'(core_grant), 32'(g[0]));
    chk("dbg_grant", 32'(dbg_grant), 32'(g[1]));
    chk("core_stall", 32'(core_stall), 32'(creq && !g[0]));
    chk("mem_read_en", 32'(mem_read_en),
        g[0] ? 32'(!core_write_en) : g[1] ? 32'(!dbg_we) : 32'd0);
    chk("mem_write_en", 32'(mem_write_en),
        g[0] ? 32'(core_write_en) : g[1] ? 32'(dbg_we) : 32'd0);
    chk("mem_addr", mem_addr, g[0] ? core_addr : g[1] ? dbg_addr : 32'd0);
    chk("mem_store_size", 32'(mem_store_size),
        g[0] ? 32'(core_store_size) : g[1] ? 32'(dbg_store_size) : 32'd0);
    chk("mem_write_data", mem_write_data,
        g[0] ? core_write_data : g[1] ? dbg_write_data : 32'd0);
    chk("core_read_valid", 32'(core_read_valid), 32'(m_owner == 1));
    chk("dbg_read_valid", 32'(dbg_read_valid), 32'(m_owner == 2));
    chk("core_read_data", core_read_data, (m_owner == 1) ? m_rdata : 32'd0);
    chk("dbg_read_data", dbg_read_data, (m_owner == 2) ? m_rdata : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_core(input bit re, input bit we, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] d);
    core_read_en = re; core_write_en = we; core_addr = a;
    core_store_size = sz; core_write_data = d;
  endtask

  task automatic drv_dbg(input bit req, input bit we, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] d);
    dbg_req = req; dbg_we = we; dbg_addr = a;
    dbg_store_size = sz; dbg_write_data = d;
  endtask

  initial begin
    rst = 1'b1;
    drv_core(1, 0, 32'h10, 2'd2, 32'd0);
    drv_dbg(0, 0, 32'd0, 2'd0, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("lit_rst_core_grant", 32'(core_grant), 32'd0);
      chk("lit_rst_mem_read_en", 32'(mem_read_en), 32'd0);
      chk("lit_rst_core_valid", 32'(core_read_valid), 32'd0);
    end

    // Core read of 0x10.
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("lit_core_grant", 32'(core_grant), 32'd1);
    chk("lit_core_mem_read_en", 32'(mem_read_en), 32'd1);
    tick(); drv_core(0, 0, 32'd0, 2'd0, 32'd0);
    @(negedge clk);
    chk("lit_core_valid", 32'(core_read_valid), 32'd1);
    chk("lit_core_data", core_read_data, 32'hC0DE0004);
    chk("lit_core_dbg_valid", 32'(dbg_read_valid), 32'd0);

    // Debug write then read back of 0x20.
    tick(); drv_dbg(1, 1, 32'h20, 2'd2, 32'hDEADBEEF);
    @(negedge clk);
    chk("lit_dbg_wr_grant", 32'(dbg_grant), 32'd1);
    chk("lit_dbg_mem_write_en", 32'(mem_write_en), 32'd1);
    tick(); drv_dbg(1, 0, 32'h20, 2'd2, 32'd0);
    tick(); drv_dbg(0, 0, 32'd0, 2'd0, 32'd0);
    @(negedge clk);
    chk("lit_dbg_valid", 32'(dbg_read_valid), 32'd1);
    chk("lit_dbg_data", dbg_read_data, 32'hDEADBEEF);

    // Interleaved owners: core, dbg, core.
    tick(); drv_core(1, 0, 32'h30, 2'd2, 32'd0);
    tick(); drv_core(0, 0, 32'd0, 2'd0, 32'd0); drv_dbg(1, 0, 32'h40, 2'd2, 32'd0);
    @(negedge clk);
    chk("lit_il_core_data", core_read_data, 32'hC0DE000C);
    tick(); drv_dbg(0, 0, 32'd0, 2'd0, 32'd0); drv_core(1, 0, 32'h50, 2'd2, 32'd0);
    @(negedge clk);
    chk("lit_il_dbg_data", dbg_read_data, 32'hC0DE0010);
    chk("lit_il_core_valid0", 32'(core_read_valid), 32'd0);
    tick(); drv_core(0, 0, 32'd0, 2'd0, 32'd0);
    @(negedge clk);
    chk("lit_il_core_data2", core_read_data, 32'hC0DE0014);

    // Back-to-back core reads; store with both enables; read back.
    tick(); drv_core(1, 0, 32'h60, 2'd2, 32'd0);
    tick(); drv_core(1, 0, 32'h64, 2'd2, 32'd0);
    tick(); drv_core(1, 1, 32'h70, 2'd1, 32'h12345678);
    tick(); drv_core(1, 0, 32'h70, 2'd2, 32'd0);
    tick(); drv_core(0, 0, 32'd0, 2'd0, 32'd0);
    @(negedge clk);
    chk("lit_rw_as_write", core_read_data, 32'h12345678);

    // Debug request refused one cycle then cancelled.
    tick(); drv_core(1, 0, 32'h80, 2'd2, 32'd0); drv_dbg(1, 0, 32'h84, 2'd0, 32'd0);
    tick(); drv_dbg(0, 0, 32'd0, 2'd0, 32'd0);
    tick(); drv_core(0, 0, 32'd0, 2'd0, 32'd0);

    // Both ports held: guard forces debug on cycle MAX_WAIT+1.
    tick(); drv_core(1, 0, 32'h90, 2'd2, 32'd0); drv_dbg(1, 0, 32'hA0, 2'd2, 32'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("lit_starve_dbg_grant", 32'(dbg_grant), 32'(GUARD && i == MAX_WAIT + 1));
      chk("lit_starve_stall", 32'(core_stall), 32'(GUARD && i == MAX_WAIT + 1));
      tick();
      if (GUARD && i == MAX_WAIT + 1) drv_dbg(0, 0, 32'd0, 2'd0, 32'd0);
    end
    drv_core(0, 0, 32'd0, 2'd0, 32'd0); drv_dbg(0, 0, 32'd0, 2'd0, 32'd0);

    // Reset in the cycle after a core read grant.
    tick(); drv_core(1, 0, 32'hB0, 2'd2, 32'd0);
    @(negedge clk);
    chk("lit_inflight_grant", 32'(core_grant), 32'd1);
    tick(); rst = 1'b1; drv_core(0, 0, 32'd0, 2'd0, 32'd0);
    @(negedge clk);
    chk("lit_inflight_valid_rst", 32'(core_read_valid), 32'd0);
    chk("lit_inflight_data_rst", core_read_data, 32'd0);
    tick(); tick(); rst = 1'b0;
    @(negedge clk);
    chk("lit_inflight_valid_post", 32'(core_read_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lit_inflight_valid_post2", 32'(core_read_valid), 32'd0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-ported `data_memory` between two requesters: the core LSU (port 0) and a debug/DMA port (port 1). It grants one access per cycle and steers that requester's controls onto the memory. The memory's one-cycle read data is returned to whichever port issued the read. When the core loses arbitration, the block asserts `core_stall`, which drives the execute-stage stall.

## Interface
Parameters:
- `MAX_WAIT`, default 4: number of cycles a debug request may be refused before it is forced through (range 1–15).

Ports (name, direction, width, meaning):
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `core_read_en`, input, 1: LSU load request.
- `core_write_en`, input, 1: LSU store request.
- `core_addr`, input, 32: LSU byte address.
- `core_store_size`, input, 2: LSU store size (byte/half/word encoding).
- `core_write_data`, input, 32: LSU store data.
- `core_grant`, output, 1: LSU access accepted this cycle.
- `core_stall`, output, 1: LSU is requesting but not granted.
- `core_read_data`, output, 32: load data returned to LSU.
- `core_read_valid`, output, 1: `core_read_data` is valid.
- `dbg_req`, input, 1: debug access request.
- `dbg_we`, input, 1: 1 = write, 0 = read.
- `dbg_addr`, input, 32: debug byte address.
- `dbg_store_size`, input, 2: debug store size.
- `dbg_write_data`, input, 32: debug store data.
- `dbg_grant`, output, 1: debug access accepted this cycle.
- `dbg_read_data`, output, 32: read data returned to debug.
- `dbg_read_valid`, output, 1: `dbg_read_data` is valid.
- `mem_read_en`, output, 1: to `data_memory`.
- `mem_write_en`, output, 1: to `data_memory`.
- `mem_addr`, output, 32: to `data_memory`.
- `mem_store_size`, output, 2: to `data_memory`.
- `mem_write_data`, output, 32: to `data_memory`.
- `mem_read_data`, input, 32: from `data_memory`, valid one cycle after `mem_read_en`.

## Operation
- Core request is `core_read_en | core_write_en`. If both are asserted, the access is treated as a write.
- Default policy is core priority: the debug port is granted only when there is no core request in the same cycle.
- Grants are combinational and mutually exclusive. At most one of `core_grant` and `dbg_grant` is high in any cycle.
- The memory outputs are a mux of the granted port's signals. With no grant, `mem_read_en` and `mem_write_en` are 0, and the address, size and data outputs are 0.
- `core_stall = core request & ~core_grant`.
- Read-return FSM, one register `rd_owner` of type `arb_owner_e`:
  - States: `OWNER_NONE`, `OWNER_CORE`, `OWNER_DBG`.
  - Next state is the granted reader, or `OWNER_NONE` when the granted access is a write or there is no grant.
- Each cycle, `mem_read_data` is routed to the port selected by the current `rd_owner`. The matching `*_read_valid` is 1 and the other is 0.
- Handshake: `dbg_req` and its payload are held stable until `dbg_grant`. Dropping `dbg_req` before grant is legal and cancels the request.
- The core sees back-pressure only through `core_stall`. The LSU holds its request while stalled.

## Timing
- Grant: zero latency (same cycle as the request).
- Read data: valid exactly one cycle after the grant. Back-to-back reads from either port return on consecutive cycles with no bubble.
- Interleaved owners: for the sequence core read, dbg read, core read, `rd_owner` steps CORE, DBG, CORE, and each valid lands on the correct port.
- Reset values:
  - `rd_owner` = `OWNER_NONE`, so both `*_read_valid` are 0 and both `*_read_data` are 0.
  - Wait counter = 0.
  - All grants and `mem_*` enables are 0 while `rst` is high.
- Reset asserted while a read is in flight: the pending return is dropped, and no valid is produced after reset releases.
- `*_read_data` is 0 whenever the matching valid is 0.

## Configuration
- `DATA_MEM_ARB_STARVE_GUARD_EN` defined:
  - A 4-bit wait counter increments each cycle that `dbg_req` is high and refused, saturating at `MAX_WAIT`.
  - When the counter equals `MAX_WAIT`, the debug port wins over the core for one cycle, and `core_stall` is high that cycle.
  - The counter clears on `dbg_grant` or when `dbg_req` is low.
- Not defined: strict core priority with no counter. The debug port may starve indefinitely.

## Structure
- Add to the shared package `mem_utils`:
  - the `arb_owner_e` enum;
  - the store-size encodings (`SIZE_BYTE`=0, `SIZE_HALF`=1, `SIZE_WORD`=2), which `lsu` and `data_memory` also use.
- One sub-module, `arb_starve_counter`: the saturating wait counter. It is instantiated only under `DATA_MEM_ARB_STARVE_GUARD_EN`.
- `core_top` instantiates this block between `lsu` and `data_memory`, and ties `ex_stall` to `core_stall`.

## Test plan
- Core read of 0x10 with no debug request → `core_grant`=1 and `mem_read_en`=1 in the same cycle; next cycle `core_read_valid`=1 with the memory word, and `dbg_read_valid`=0.
- Debug write 0xDEADBEEF to 0x20 (word) with the core idle → `dbg_grant`=1 and `mem_write_en`=1; a later debug read of 0x20 returns 0xDEADBEEF with `dbg_read_valid`=1.
- Core read and debug read both held continuously, guard enabled, `MAX_WAIT`=4 → debug is refused for 4 cycles, granted on the 5th with `core_stall`=1 that cycle, and the counter returns to 0.
- Same stimulus with the guard disabled → `dbg_grant` stays 0 for 20 cycles and `core_stall` stays 0.
- Core read, then debug read, then core read on consecutive cycles (core idle on the middle cycle) → valids appear as core, dbg, core on the next three cycles, each carrying its own address's data.
- Assert `rst` in the cycle after a core read grant → `core_read_valid` stays 0 through and after reset, and all outputs are 0 during reset.
